// File: rtl/seletor_estado_botoes.sv
// Debounced N-button selector producing the display controller's estado code.
// Define SYNC_QUADRO_EN to apply state changes only on frame_fim pulses.
module seletor_estado_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int ESTADO_W        = 4,
    parameter int DEBOUNCE_CICLOS = 250000,
    parameter int MODO            = 0,
    parameter int TIMEOUT_CICLOS  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                frame_fim,
    output logic [ESTADO_W-1:0] estado,
    output logic                estado_mudou,
    output logic [N_BOTOES-1:0] botao_evento
);
    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam int TMO_W = (TIMEOUT_CICLOS > 0) ? $clog2(TIMEOUT_CICLOS + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'((TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0);
    localparam bit TMO_EN = (MODO == 1) && (TIMEOUT_CICLOS > 0);

    logic [N_BOTOES-1:0] sync1, sync2, deb, deb_d, subida;
    logic [CNT_W-1:0]    deb_cnt [N_BOTOES];
    logic [TMO_W-1:0]    tmo_cnt;
    logic [ESTADO_W-1:0] req, req_next, held_code, evt_code;
    logic                evt_any, tmo_fim, aplicar;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // with = the two synchroniser stages would collapse into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            deb          <= '0;
            deb_d        <= '0;
            botao_evento <= '0;
            // NOTE: the counter array is a handful of flops, not RAM, so it is
            // cleared on reset like any other state.
            for (int i = 0; i < N_BOTOES; i++) deb_cnt[i] <= '0;
        end else begin
            sync1        <= botoes;
            sync2        <= sync1;
            deb_d        <= deb;
            botao_evento <= subida;
            for (int i = 0; i < N_BOTOES; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_MAX) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign subida  = deb & ~deb_d;
    assign evt_any = |subida;

    // Scan from the top so the lowest index is written last and wins.
    // NOTE: every always_comb output gets a default first, otherwise paths
    // that skip an assignment infer latches.
    always_comb begin
        held_code = '0;
        evt_code  = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (deb[i])    held_code = ESTADO_W'(i + 1);
            if (subida[i]) evt_code  = ESTADO_W'(i + 1);
        end
    end

    assign tmo_fim = TMO_EN && (req != '0) && (tmo_cnt == TMO_MAX);

    always_comb begin
        req_next = req;
        if (MODO == 0)    req_next = held_code;
        else if (evt_any) req_next = (req == evt_code) ? '0 : evt_code;
        else if (tmo_fim) req_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst || !TMO_EN || evt_any || (req == '0) || tmo_fim) tmo_cnt <= '0;
        else                                                     tmo_cnt <= tmo_cnt + 1'b1;
    end

`ifdef SYNC_QUADRO_EN
    assign aplicar = frame_fim && (req != estado);
`else
    logic unused_frame_fim;
    assign unused_frame_fim = frame_fim;
    assign aplicar = (req != estado);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            req          <= '0;
            estado       <= '0;
            estado_mudou <= 1'b0;
        end else begin
            req          <= req_next;
            estado_mudou <= 1'b0;
            if (aplicar) begin
                estado       <= req;
                estado_mudou <= 1'b1;
            end
        end
    end
endmodule
